// File: rtl/eai_req_responder_pkg.sv
// Shared definitions for the EAI request/response responder: opcode and
// command-space constants, funct3 flag positions, FSM state encoding.
package eai_req_responder_pkg;

  localparam logic [6:0]  EAI_CUSTOM0_OPC = 7'b0001011;
  localparam int unsigned EAI_NUM_CMD     = 32'd16;

  localparam int unsigned EAI_XD_BIT  = 32'd14;
  localparam int unsigned EAI_XS1_BIT = 32'd13;
  localparam int unsigned EAI_XS2_BIT = 32'd12;

  typedef enum logic [1:0] {
    EAI_ST_IDLE     = 2'd0,
    EAI_ST_DISPATCH = 2'd1,
    EAI_ST_WAIT     = 2'd2,
    EAI_ST_RESP     = 2'd3
  } eai_state_e;

  // An instruction is dispatchable only with the custom opcode and an in-range funct7.
  function automatic logic eai_cmd_legal(input logic [31:0] instr,
                                         input logic [6:0]  opc,
                                         input int unsigned num_cmd);
    logic opc_ok;
    logic f7_ok;
    opc_ok = (instr[6:0] == opc);
    f7_ok  = ({25'd0, instr[31:25]} < num_cmd);
    return opc_ok && f7_ok;
  endfunction

endpackage

// File: rtl/eai_req_responder.sv
// Responder end of the EAI channel: accepts one custom-0 instruction, dispatches
// it to the engine, waits for completion or timeout, and returns a tagged response.
module eai_req_responder
  import eai_req_responder_pkg::*;
#(
  parameter logic [6:0]      CUSTOM_OPC = EAI_CUSTOM0_OPC,
  parameter int unsigned     NUM_CMD    = EAI_NUM_CMD,
  parameter int unsigned     TO_W       = 32'd16,
  parameter logic [TO_W-1:0] TO_CYC     = 16'd4095
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        eai_req_valid,
  output logic        eai_req_ready,
  input  logic [31:0] eai_req_instr,
  input  logic [31:0] eai_req_rs1,
  input  logic [31:0] eai_req_rs2,
  input  logic [1:0]  eai_req_itag,
  output logic        eai_rsp_valid,
  input  logic        eai_rsp_ready,
  output logic [31:0] eai_rsp_wdat,
  output logic [1:0]  eai_rsp_itag,
  output logic        eai_rsp_err,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [6:0]  cmd_code,
  output logic [31:0] cmd_rs1,
  output logic [31:0] cmd_rs2,
  output logic        cmd_xd,
  input  logic        done_valid,
  input  logic [31:0] done_data,
  output logic        busy
);

  localparam logic [TO_W-1:0] TO_ZERO = {TO_W{1'b0}};
  localparam logic [TO_W-1:0] TO_ONE  = {{(TO_W-1){1'b0}}, 1'b1};
  localparam logic [TO_W-1:0] TO_MAX  = {TO_W{1'b1}};
  localparam logic [TO_W-1:0] TO_LAST = TO_CYC - TO_ONE;

  eai_state_e      state_r;
  logic [TO_W-1:0] to_cnt_r;
  logic            legal_s;
  logic            to_hit_s;
  logic            instr_unused_s;

  assign legal_s  = eai_cmd_legal(eai_req_instr, CUSTOM_OPC, NUM_CMD);
  assign to_hit_s = (TO_CYC != TO_ZERO) && (to_cnt_r == TO_LAST);

  // Only funct7, the xd flag and the opcode steer this block; the rest of the word is the engine's concern.
  assign instr_unused_s = ^{eai_req_instr[24:15], eai_req_instr[13:7]};

  // Request/dispatch/wait/response FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= EAI_ST_IDLE;
      to_cnt_r      <= TO_ZERO;
      eai_req_ready <= 1'b1;
      eai_rsp_valid <= 1'b0;
      eai_rsp_wdat  <= 32'd0;
      eai_rsp_itag  <= 2'd0;
      eai_rsp_err   <= 1'b0;
      cmd_valid     <= 1'b0;
      cmd_code      <= 7'd0;
      cmd_rs1       <= 32'd0;
      cmd_rs2       <= 32'd0;
      cmd_xd        <= 1'b0;
      busy          <= 1'b0;
    end else begin
      case (state_r)
        EAI_ST_IDLE: begin
          if (eai_req_valid && eai_req_ready) begin
            cmd_code      <= eai_req_instr[31:25];
            cmd_rs1       <= eai_req_rs1;
            cmd_rs2       <= eai_req_rs2;
            cmd_xd        <= eai_req_instr[EAI_XD_BIT];
            eai_rsp_itag  <= eai_req_itag;
            eai_req_ready <= 1'b0;
            busy          <= 1'b1;
            if (legal_s) begin
              state_r   <= EAI_ST_DISPATCH;
              cmd_valid <= 1'b1;
            end else begin
              state_r       <= EAI_ST_RESP;
              eai_rsp_valid <= 1'b1;
              eai_rsp_wdat  <= 32'd0;
              eai_rsp_err   <= 1'b1;
            end
          end
        end
        EAI_ST_DISPATCH: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            to_cnt_r  <= TO_ZERO;
            // A completion coinciding with the command handshake skips WAIT entirely.
            if (done_valid) begin
              state_r       <= EAI_ST_RESP;
              eai_rsp_valid <= 1'b1;
              eai_rsp_wdat  <= cmd_xd ? done_data : 32'd0;
              eai_rsp_err   <= 1'b0;
            end else begin
              state_r <= EAI_ST_WAIT;
            end
          end
        end
        EAI_ST_WAIT: begin
          if (done_valid) begin
            state_r       <= EAI_ST_RESP;
            eai_rsp_valid <= 1'b1;
            eai_rsp_wdat  <= cmd_xd ? done_data : 32'd0;
            eai_rsp_err   <= 1'b0;
          end else if (to_hit_s) begin
            state_r       <= EAI_ST_RESP;
            eai_rsp_valid <= 1'b1;
            eai_rsp_wdat  <= 32'd0;
            eai_rsp_err   <= 1'b1;
          end else if (to_cnt_r != TO_MAX) begin
            to_cnt_r <= to_cnt_r + TO_ONE;
          end else begin
            to_cnt_r <= to_cnt_r;
          end
        end
        EAI_ST_RESP: begin
          if (eai_rsp_ready) begin
            state_r       <= EAI_ST_IDLE;
            eai_rsp_valid <= 1'b0;
            eai_req_ready <= 1'b1;
            busy          <= 1'b0;
          end
        end
        default: begin
          state_r       <= EAI_ST_IDLE;
          eai_req_ready <= 1'b1;
          eai_rsp_valid <= 1'b0;
          cmd_valid     <= 1'b0;
          busy          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eai_req_responder.sv
// Directed scoreboard bench for eai_req_responder: stimulus pushes expected
// responses, an independent monitor pops and compares on each response handshake.
module tb_eai_req_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        eai_req_valid = 1'b0;
  logic        eai_req_ready;
  logic [31:0] eai_req_instr = 32'd0;
  logic [31:0] eai_req_rs1 = 32'd0;
  logic [31:0] eai_req_rs2 = 32'd0;
  logic [1:0]  eai_req_itag = 2'd0;
  logic        eai_rsp_valid;
  logic        eai_rsp_ready = 1'b1;
  logic [31:0] eai_rsp_wdat;
  logic [1:0]  eai_rsp_itag;
  logic        eai_rsp_err;
  logic        cmd_valid;
  logic        cmd_ready = 1'b1;
  logic [6:0]  cmd_code;
  logic [31:0] cmd_rs1;
  logic [31:0] cmd_rs2;
  logic        cmd_xd;
  logic        done_valid = 1'b0;
  logic [31:0] done_data = 32'd0;
  logic        busy;

  typedef struct {
    logic [31:0] wdat;
    logic [1:0]  itag;
    logic        err;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_pushed = 0;
  int   n_popped = 0;

  eai_req_responder #(.TO_CYC(16'd8)) dut (
    .clk(clk), .rst(rst),
    .eai_req_valid(eai_req_valid), .eai_req_ready(eai_req_ready),
    .eai_req_instr(eai_req_instr), .eai_req_rs1(eai_req_rs1),
    .eai_req_rs2(eai_req_rs2), .eai_req_itag(eai_req_itag),
    .eai_rsp_valid(eai_rsp_valid), .eai_rsp_ready(eai_rsp_ready),
    .eai_rsp_wdat(eai_rsp_wdat), .eai_rsp_itag(eai_rsp_itag),
    .eai_rsp_err(eai_rsp_err),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_code(cmd_code),
    .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_xd(cmd_xd),
    .done_valid(done_valid), .done_data(done_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cmd(input string tag, input logic [31:0] instr,
                           input logic [31:0] rs1, input logic [31:0] rs2);
    logic [31:0] w;
    w = instr;
    chk({tag, "_cmd_valid"}, {31'd0, cmd_valid}, 32'd1);
    chk({tag, "_cmd_code"}, {25'd0, cmd_code}, {25'd0, w[31:25]});
    chk({tag, "_cmd_rs1"}, cmd_rs1, rs1);
    chk({tag, "_cmd_rs2"}, cmd_rs2, rs2);
    chk({tag, "_cmd_xd"}, {31'd0, cmd_xd}, {31'd0, w[14]});
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (!(eai_req_ready && !busy) && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_idle_timeout"}, {31'd0, eai_req_ready && !busy}, 32'd1);
  endtask

  task automatic issue(input logic [31:0] instr, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic [1:0] itag);
    eai_req_valid = 1'b1;
    eai_req_instr = instr;
    eai_req_rs1   = rs1;
    eai_req_rs2   = rs2;
    eai_req_itag  = itag;
    tick();
    eai_req_valid = 1'b0;
  endtask

  // Legal instruction: cmd_ready after rdy_dly stall cycles, done_valid done_dly cycles after the handshake.
  task automatic run_legal(input string tag, input logic [31:0] instr, input logic [31:0] rs1,
                           input logic [31:0] rs2, input logic [1:0] itag, input int rdy_dly,
                           input int done_dly, input logic [31:0] data, input logic [31:0] exp_wdat);
    rsp_t e;
    e.wdat = exp_wdat; e.itag = itag; e.err = 1'b0;
    exp_q.push_back(e);
    n_pushed++;
    cmd_ready = 1'b0;
    issue(instr, rs1, rs2, itag);
    chk({tag, "_req_ready_low"}, {31'd0, eai_req_ready}, 32'd0);
    check_cmd(tag, instr, rs1, rs2);
    for (int i = 0; i < rdy_dly; i++) begin
      tick();
      check_cmd({tag, "_stall"}, instr, rs1, rs2);
    end
    cmd_ready  = 1'b1;
    done_valid = (done_dly == 0);
    done_data  = data;
    tick();
    cmd_ready  = 1'b0;
    done_valid = 1'b0;
    if (done_dly > 0) begin
      for (int i = 1; i < done_dly; i++) tick();
      done_valid = 1'b1;
      done_data  = data;
      tick();
      done_valid = 1'b0;
    end
    chk({tag, "_rsp_valid_next"}, {31'd0, eai_rsp_valid}, 32'd1);
    wait_idle(tag);
    cmd_ready = 1'b1;
  endtask

  task automatic run_illegal(input string tag, input logic [31:0] instr, input logic [1:0] itag);
    rsp_t e;
    int   n;
    logic cmd_seen;
    e.wdat = 32'd0; e.itag = itag; e.err = 1'b1;
    exp_q.push_back(e);
    n_pushed++;
    issue(instr, 32'hAAAA_0001, 32'hAAAA_0002, itag);
    chk({tag, "_rsp_valid_cyc1"}, {31'd0, eai_rsp_valid}, 32'd1);
    cmd_seen = cmd_valid;
    n = 0;
    while (!(eai_req_ready && !busy) && n < 40) begin
      tick();
      cmd_seen = cmd_seen | cmd_valid;
      n++;
    end
    chk({tag, "_no_dispatch"}, {31'd0, cmd_seen}, 32'd0);
    chk({tag, "_idle_timeout"}, {31'd0, eai_req_ready && !busy}, 32'd1);
  endtask

  // Monitor: pops the scoreboard on every response handshake.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      if (eai_rsp_valid && eai_rsp_ready) begin
        n_popped++;
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", {31'd0, eai_rsp_valid}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_wdat", eai_rsp_wdat, e.wdat);
          chk("rsp_itag", {30'd0, eai_rsp_itag}, {30'd0, e.itag});
          chk("rsp_err", {31'd0, eai_rsp_err}, {31'd0, e.err});
        end
      end
    end
  end

  // Global watchdog so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Directed stimulus sequence.
  initial begin
    rsp_t e;
    int   n;
    tick();
    tick();
    chk("rst_req_ready", {31'd0, eai_req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, eai_rsp_valid}, 32'd0);
    chk("rst_rsp_wdat", eai_rsp_wdat, 32'd0);
    chk("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
    chk("rst_cmd_rs1", cmd_rs1, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    tick();

    run_legal("t1", 32'h0200_400B, 32'h10, 32'h20, 2'd2, 0, 3, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    run_legal("t2", 32'h0200_000B, 32'h11, 32'h22, 2'd3, 0, 2, 32'h0000_1234, 32'd0);
    run_illegal("t3", 32'h0000_0033, 2'd1);
    run_illegal("t4", 32'h2000_400B, 2'd0);
    run_legal("t4b", 32'h1E00_400B, 32'h5, 32'h6, 2'd1, 0, 1, 32'h0BAD_F00D, 32'h0BAD_F00D);
    run_legal("t5", 32'h0400_400B, 32'h33, 32'h44, 2'd0, 5, 0, 32'h55, 32'h55);
    run_legal("tlast", 32'h0600_400B, 32'h1, 32'h2, 2'd2, 0, 8, 32'hCAFE_0008, 32'hCAFE_0008);

    // Timeout: no completion, response held off for 4 cycles.
    e.wdat = 32'd0; e.itag = 2'd3; e.err = 1'b1;
    exp_q.push_back(e);
    n_pushed++;
    eai_rsp_ready = 1'b0;
    issue(32'h0800_400B, 32'h77, 32'h88, 2'd3);
    tick();
    n = 0;
    while (!eai_rsp_valid && n < 50) begin
      n++;
      tick();
    end
    chk("to_wait_cycles", n, 32'd8);
    for (int i = 0; i < 4; i++) begin
      chk("to_hold_valid", {31'd0, eai_rsp_valid}, 32'd1);
      chk("to_hold_wdat", eai_rsp_wdat, 32'd0);
      chk("to_hold_err", {31'd0, eai_rsp_err}, 32'd1);
      chk("to_hold_itag", {30'd0, eai_rsp_itag}, 32'd3);
      tick();
    end
    eai_rsp_ready = 1'b1;
    wait_idle("to");

    // Reset during WAIT abandons the instruction.
    issue(32'h0200_400B, 32'h99, 32'h98, 2'd1);
    tick();
    tick();
    chk("rw_in_wait_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rw_req_ready", {31'd0, eai_req_ready}, 32'd1);
    chk("rw_rsp_valid", {31'd0, eai_rsp_valid}, 32'd0);
    chk("rw_busy", {31'd0, busy}, 32'd0);
    done_valid = 1'b1;
    done_data  = 32'hFFFF_FFFF;
    tick();
    done_valid = 1'b0;
    chk("idle_done_ignored", {31'd0, eai_rsp_valid}, 32'd0);
    run_legal("t7", 32'h0200_400B, 32'hA, 32'hB, 2'd2, 1, 2, 32'h0000_BEEF, 32'h0000_BEEF);

    repeat (5) tick();
    chk("queue_empty", exp_q.size(), 32'd0);
    chk("rsp_count", n_popped, n_pushed);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
